// File: rtl/mem_copy_pkg.sv
// rtl/mem_copy_pkg.sv - shared types and constants for the memory copy/fill initiator
package mem_copy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_WR_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic {
    MODE_COPY = 1'b0,
    MODE_FILL = 1'b1
  } mode_e;

  localparam logic [31:0] WordBytes = 32'd4;

endpackage

// File: rtl/mem_copy_initiator.sv
// rtl/mem_copy_initiator.sv - word copy/fill bus initiator for a single-outstanding memory port
module mem_copy_initiator
  import mem_copy_pkg::*;
#(
  parameter int LenW       = 16,
  parameter int TimeoutCyc = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            mode_i,
  input  logic [31:0]     src_addr_i,
  input  logic [31:0]     dst_addr_i,
  input  logic [LenW-1:0] len_i,
  input  logic [31:0]     pattern_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            req_o,
  output logic            we_o,
  output logic [3:0]      be_o,
  output logic [31:0]     addr_o,
  output logic [31:0]     wdata_o,
  input  logic            rvalid_i,
  input  logic [31:0]     rdata_i
);

  localparam int            TmrW    = $clog2(TimeoutCyc + 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TimeoutCyc - 1);

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [31:0]     src_q, src_d;
  logic [31:0]     dst_q, dst_d;
  logic [LenW-1:0] remaining_q, remaining_d;
  logic [31:0]     pattern_q, pattern_d;
  logic [31:0]     data_q, data_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic            err_q, err_d;

  // State register and transfer context; reset drops any transfer in flight without done_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_COPY;
      src_q       <= '0;
      dst_q       <= '0;
      remaining_q <= '0;
      pattern_q   <= '0;
      data_q      <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      remaining_q <= remaining_d;
      pattern_q   <= pattern_d;
      data_q      <= data_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
    end
  end

  // Next-state and bus outputs; bus fields stay zero whenever no request is issued.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    src_d       = src_q;
    dst_d       = dst_q;
    remaining_d = remaining_q;
    pattern_d   = pattern_q;
    data_d      = data_q;
    timer_d     = timer_q;
    err_d       = err_q;
    req_o       = 1'b0;
    we_o        = 1'b0;
    be_o        = 4'h0;
    addr_o      = '0;
    wdata_o     = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mode_d      = mode_e'(mode_i);
          src_d       = src_addr_i;
          dst_d       = dst_addr_i;
          remaining_d = len_i;
          pattern_d   = pattern_i;
          err_d       = 1'b0;
          if ((src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (len_i == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = mode_i ? ST_WR : ST_RD;
          end
        end
      end
      ST_RD: begin
        req_o   = 1'b1;
        addr_o  = src_q;
        timer_d = '0;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (rvalid_i) begin
          data_d  = rdata_i;
          state_d = ST_WR;
        end else if (timer_q == TmrLast) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      ST_WR: begin
        req_o   = 1'b1;
        we_o    = 1'b1;
        be_o    = 4'hF;
        addr_o  = dst_q;
        wdata_o = (mode_q == MODE_FILL) ? pattern_q : data_q;
        timer_d = '0;
        state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (rvalid_i) begin
          remaining_d = remaining_q - LenW'(1);
          src_d       = src_q + WordBytes;
          dst_d       = dst_q + WordBytes;
          if (remaining_q == LenW'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = (mode_q == MODE_FILL) ? ST_WR : ST_RD;
          end
        end else if (timer_q == TmrLast) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A response nobody asked for is flagged but does not stop the transfer.
    if (rvalid_i && (state_q != ST_RD_WAIT) && (state_q != ST_WR_WAIT)) begin
      err_d = 1'b1;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);
  assign err_o  = err_q;

  a_req_not_b2b : assert property (@(posedge clk_i) disable iff (rst_i) req_o |=> !req_o);
  a_addr_align  : assert property (@(posedge clk_i) disable iff (rst_i) req_o |-> (addr_o[1:0] == 2'b00));
  a_be_write    : assert property (@(posedge clk_i) disable iff (rst_i) (be_o == 4'hF) == (req_o && we_o));

endmodule
